// File: rtl/i2c_sram_slave_sync.sv
// I2C slave SRAM oversampling SCL/SDA on the system clock; burst read/write with auto-increment.
// Optional write protect input enabled by defining I2C_SRAM_WP_EN.
module i2c_sram_slave_sync #(
  parameter int unsigned MEM_ADDR_W  = 8,
  parameter int unsigned ADDR_BYTES  = (MEM_ADDR_W + 7) / 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
`ifdef I2C_SRAM_WP_EN
  input  logic                  wp,
`endif
  input  logic [6:0]            my_addr,
  output logic                  sda_oe,
  output logic [7:0]            curr_data,
  output logic [6:0]            rcvd_device_address,
  output logic                  rcvd_mode,
  output logic [MEM_ADDR_W-1:0] mem_ptr,
  output logic [3:0]            state,
  output logic                  busy
);

  localparam int unsigned Depth = 1 << MEM_ADDR_W;
  localparam logic [1:0] AddrBytesW = 2'(ADDR_BYTES);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StDevAddr  = 4'd1,
    StDevAck   = 4'd2,
    StMaddr    = 4'd3,
    StMaddrAck = 4'd4,
    StWdata    = 4'd5,
    StWdataAck = 4'd6,
    StRdata    = 4'd7,
    StRdataAck = 4'd8,
    StIgnore   = 4'd9
  } state_e;

  // Synchronisers reset to 1 so an idle bus produces no spurious edges.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign sda_rise   = sda_s & ~sda_prev_q;
  assign sda_fall   = ~sda_s & sda_prev_q;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  logic wp_on;
`ifdef I2C_SRAM_WP_EN
  assign wp_on = wp;
`else
  assign wp_on = 1'b0;
`endif

  state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shift_q, shift_d, curr_data_q, curr_data_d;
  logic [MEM_ADDR_W-1:0] addr_acc_q, addr_acc_d, mem_ptr_q, mem_ptr_d, ptr_inc;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, rcvd_mode_q, rcvd_mode_d, mem_we;
  logic [6:0] rcvd_addr_q, rcvd_addr_d;
  logic [7:0] mem [Depth];
  logic [7:0] rd_cur, rd_next;
  logic rx_bit, byte_done;

  assign ptr_inc   = mem_ptr_q + MEM_ADDR_W'(1);
  assign rd_cur    = mem[mem_ptr_q];
  assign rd_next   = mem[ptr_inc];
  assign rx_bit    = scl_rise && (bit_cnt_q != 4'd8);
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    addr_acc_d  = addr_acc_q;
    mem_ptr_d   = mem_ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    curr_data_d = curr_data_q;
    rcvd_addr_d = rcvd_addr_q;
    rcvd_mode_d = rcvd_mode_q;
    mem_we      = 1'b0;
    if (start_cond) begin
      state_d   = StDevAddr;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_cond) begin
      state_d   = StIdle;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      // Ack states span from the falling edge after bit 8 to the next falling edge.
      case (state_q)
        StDevAddr, StMaddr, StWdata: begin
          if (rx_bit) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = 4'd0;
            if (state_q == StDevAddr) begin
              rcvd_addr_d = shift_q[7:1];
              rcvd_mode_d = shift_q[0];
              if (shift_q[7:1] == my_addr) begin
                state_d  = StDevAck;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = StIgnore;
                busy_d  = 1'b0;
              end
            end else if (state_q == StMaddr) begin
              addr_acc_d = MEM_ADDR_W'({addr_acc_q, shift_q});
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = StMaddrAck;
              sda_oe_d   = 1'b1;
            end else begin
              curr_data_d = shift_q;
              state_d     = StWdataAck;
              if (!wp_on) begin
                mem_we    = 1'b1;
                mem_ptr_d = ptr_inc;
                sda_oe_d  = 1'b1;
              end
            end
          end
        end
        StDevAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rcvd_mode_q) begin
              state_d  = StRdata;
              shift_d  = rd_cur;
              sda_oe_d = ~rd_cur[7];
            end else begin
              state_d    = StMaddr;
              byte_cnt_d = 2'd0;
              addr_acc_d = '0;
              sda_oe_d   = 1'b0;
            end
          end
        end
        StMaddrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (byte_cnt_q == AddrBytesW) begin
              mem_ptr_d = addr_acc_q;
              state_d   = StWdata;
            end else begin
              state_d = StMaddr;
            end
          end
        end
        StWdataAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWdata;
          end
        end
        StRdata: begin
          // Rotate rather than shift so the full byte is intact after 8 bits.
          if (rx_bit) begin
            shift_d   = {shift_q[6:0], shift_q[7]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d     = StRdataAck;
            sda_oe_d    = 1'b0;
            curr_data_d = shift_q;
            bit_cnt_d   = 4'd0;
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            mem_ptr_d = ptr_inc;
            if (!sda_s) begin
              state_d   = StRdata;
              shift_d   = rd_next;
              bit_cnt_d = 4'd0;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 8'd0;
      addr_acc_q  <= '0;
      mem_ptr_q   <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      curr_data_q <= 8'd0;
      rcvd_addr_q <= 7'd0;
      rcvd_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      addr_acc_q  <= addr_acc_d;
      mem_ptr_q   <= mem_ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      curr_data_q <= curr_data_d;
      rcvd_addr_q <= rcvd_addr_d;
      rcvd_mode_q <= rcvd_mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_ptr_q] <= shift_q;
  end

  assign sda_oe              = sda_oe_q;
  assign curr_data           = curr_data_q;
  assign rcvd_device_address = rcvd_addr_q;
  assign rcvd_mode           = rcvd_mode_q;
  assign mem_ptr             = mem_ptr_q;
  assign state               = state_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_i2c_sram_slave_sync.sv
// Bench: two slaves (8-bit and 10-bit memory address) share one open-drain I2C bus.
module tb_i2c_sram_slave_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, scl, sda_m;
  logic oe8, oe10;
  wire  sda_line = sda_m & ~oe8 & ~oe10;

  logic [7:0] cd8, cd10;
  logic [6:0] rda8, rda10;
  logic rm8, rm10, busy8, busy10;
  logic [7:0] ptr8;
  logic [9:0] ptr10;
  logic [3:0] st8, st10;
`ifdef I2C_SRAM_WP_EN
  logic wp = 1'b0;
`endif

  i2c_sram_slave_sync #(.MEM_ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
`ifdef I2C_SRAM_WP_EN
    .wp(wp),
`endif
    .my_addr(7'h3C), .sda_oe(oe8), .curr_data(cd8), .rcvd_device_address(rda8),
    .rcvd_mode(rm8), .mem_ptr(ptr8), .state(st8), .busy(busy8)
  );

  i2c_sram_slave_sync #(.MEM_ADDR_W(10)) dut10 (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
`ifdef I2C_SRAM_WP_EN
    .wp(wp),
`endif
    .my_addr(7'h50), .sda_oe(oe10), .curr_data(cd10), .rcvd_device_address(rda10),
    .rcvd_mode(rm10), .mem_ptr(ptr10), .state(st10), .busy(busy10)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b;
    wclk(8);
    scl = 1'b1;
    wclk(4);
    s = sda_line;
    wclk(4);
    scl = 1'b0;
    wclk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(~ack, s);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(8);
    scl = 1'b1;   wclk(8);
    sda_m = 1'b0; wclk(8);
    scl = 1'b0;   wclk(8);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(8);
    scl = 1'b1;   wclk(8);
    sda_m = 1'b1; wclk(8);
  endtask

  // START, device address + W, memory address bytes; ok = every byte ACKed.
  task automatic set_ptr(input logic is10, input logic [15:0] maddr, output logic ok);
    logic a0, a1, a2;
    i2c_start();
    send_byte({(is10 ? 7'h50 : 7'h3C), 1'b0}, a0);
    a2 = 1'b1;
    if (is10) send_byte(maddr[15:8], a2);
    send_byte(maddr[7:0], a1);
    ok = a0 & a1 & a2;
  endtask

  typedef struct {
    string       name;
    logic        is10;
    logic [15:0] maddr;
    logic [7:0]  exp_data;
    logic [15:0] exp_ptr;
  } rd_vec_t;

  rd_vec_t vecs[6];

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic a, ok, s;
    logic [7:0] d;

    vecs[0] = '{"rd 0x10",  1'b0, 16'h0010, 8'hA5, 16'h0011};
    vecs[1] = '{"rd 0x11",  1'b0, 16'h0011, 8'h5A, 16'h0012};
    vecs[2] = '{"rd 0xFF",  1'b0, 16'h00FF, 8'h11, 16'h0000};
    vecs[3] = '{"rd 0x00",  1'b0, 16'h0000, 8'h22, 16'h0001};
    vecs[4] = '{"rd 0x20",  1'b0, 16'h0020, 8'h77, 16'h0021};
    vecs[5] = '{"rd 0x37F", 1'b1, 16'h037F, 8'hC3, 16'h0380};

    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    wclk(5);
    chk("rst sda_oe", 32'(oe8), 0);
    chk("rst state", 32'(st8), 0);
    chk("rst curr_data", 32'(cd8), 0);
    chk("rst rcvd_addr", 32'(rda8), 0);
    chk("rst rcvd_mode", 32'(rm8), 0);
    chk("rst mem_ptr", 32'(ptr8), 0);
    chk("rst busy", 32'(busy8), 0);
    reset = 1'b0;
    wclk(10);

    // Burst write 0xA5, 0x5A at 0x10.
    i2c_start();
    send_byte(8'h78, a); chk("t1 dev ack", 32'(a), 1);
    send_byte(8'h10, a); chk("t1 maddr ack", 32'(a), 1);
    send_byte(8'hA5, a); chk("t1 d0 ack", 32'(a), 1);
    send_byte(8'h5A, a); chk("t1 d1 ack", 32'(a), 1);
    chk("t1 busy", 32'(busy8), 1);
    chk("t1 curr_data", 32'(cd8), 32'h5A);
    i2c_stop();
    chk("t1 mem_ptr", 32'(ptr8), 32'h12);
    chk("t1 busy after stop", 32'(busy8), 0);
    chk("t1 state idle", 32'(st8), 0);

    // Repeated START read: ACK then NACK.
    set_ptr(1'b0, 16'h0010, ok); chk("t2 set_ptr ack", 32'(ok), 1);
    i2c_start();
    send_byte(8'h79, a); chk("t2 dev R ack", 32'(a), 1);
    recv_byte(1'b1, d); chk("t2 rd0", 32'(d), 32'hA5);
    recv_byte(1'b0, d); chk("t2 rd1", 32'(d), 32'h5A);
    chk("t2 rcvd_mode", 32'(rm8), 1);
    chk("t2 curr_data", 32'(cd8), 32'h5A);
    chk("t2 state ignore", 32'(st8), 9);
    i2c_stop();
    chk("t2 mem_ptr", 32'(ptr8), 32'h12);

    // Non-matching address is ignored.
    i2c_start();
    send_byte(8'h7A, a); chk("t3 no ack", 32'(a), 0);
    chk("t3 state ignore", 32'(st8), 9);
    chk("t3 rcvd_addr", 32'(rda8), 32'h3D);
    chk("t3 busy", 32'(busy8), 0);
    send_byte(8'h10, a); chk("t3 byte no ack", 32'(a), 0);
    send_byte(8'h99, a);
    i2c_stop();

    // Pointer wrap on write.
    set_ptr(1'b0, 16'h00FF, ok); chk("t4 set_ptr ack", 32'(ok), 1);
    send_byte(8'h11, a); chk("t4 d0 ack", 32'(a), 1);
    send_byte(8'h22, a); chk("t4 d1 ack", 32'(a), 1);
    i2c_stop();
    chk("t4 mem_ptr wrap", 32'(ptr8), 32'h01);

    // 10-bit addressing, upper bits of first address byte discarded.
    set_ptr(1'b1, 16'hFF7F, ok); chk("t5 set_ptr ack", 32'(ok), 1);
    send_byte(8'hC3, a); chk("t5 d0 ack", 32'(a), 1);
    i2c_stop();
    chk("t5 mem_ptr", 32'(ptr10), 32'h380);
    chk("t5 curr_data", 32'(cd10), 32'hC3);

    // STOP mid-byte discards the partial byte.
    set_ptr(1'b0, 16'h0020, ok);
    send_byte(8'h77, a); chk("t6 d0 ack", 32'(a), 1);
    i2c_stop();
    set_ptr(1'b0, 16'h0020, ok);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, s);
    i2c_stop();
    chk("t6 state idle", 32'(st8), 0);
    chk("t6 mem_ptr", 32'(ptr8), 32'h20);

    // Reset while driving a 0 read bit (0xA5 bit6).
    set_ptr(1'b0, 16'h0010, ok);
    i2c_start();
    send_byte(8'h79, a);
    bit_cycle(1'b1, s); chk("t7 bit7", 32'(s), 1);
    chk("t7 driving low", 32'(oe8), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t7 sda_oe after reset", 32'(oe8), 0);
    chk("t7 state after reset", 32'(st8), 0);
    chk("t7 busy after reset", 32'(busy8), 0);
    chk("t7 mem_ptr after reset", 32'(ptr8), 0);
    @(negedge clk);
    reset = 1'b0; sda_m = 1'b1;
    wclk(4);
    scl = 1'b1;
    wclk(20);

    for (int i = 0; i < 6; i++) begin
      set_ptr(vecs[i].is10, vecs[i].maddr, ok);
      chk({vecs[i].name, " addr ack"}, 32'(ok), 1);
      i2c_start();
      send_byte({(vecs[i].is10 ? 7'h50 : 7'h3C), 1'b1}, a);
      recv_byte(1'b0, d);
      i2c_stop();
      chk({vecs[i].name, " data"}, 32'(d), 32'(vecs[i].exp_data));
      chk({vecs[i].name, " ptr"}, vecs[i].is10 ? 32'(ptr10) : 32'(ptr8),
          32'(vecs[i].exp_ptr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
